adc_pixel_framer: RTL and testbench
===================================

# adc_pixel_framer

Downstream consumer of the 4-lane 8:1 LVDS deserializer that carries the AFE's two 16-bit channels (A in `rx_data[31:16]`, B in `rx_data[15:0]`) on the 54 MHz sensor clock. It trains word alignment against the AFE test pattern by pulsing `bitslip` into the deserializer. Once locked, it frames active-line pixel pairs using `hblank` from the CCD timing generator. Framed pairs are buffered in a small FIFO and presented on a valid/ready stream to the capture/host path.

## Interface

Parameters:
- `TRAIN_PATTERN`, default 16'hF00F: AFE test word expected on both channels during training.
- `LOCK_COUNT`, default 16: consecutive matching words required for lock.
- `SLIP_WAIT`, default 4: settle cycles after each `bitslip` pulse.
- `MAX_SLIPS`, default 7: slip attempts before failure (8 bit positions).
- `LINE_PAIRS`, default 800: pixel pairs per active line.
- `FIFO_DEPTH`, default 16: pair FIFO entries (power of two).

Ports:
- `clk` in 1: sensor clock (one clock domain; same clock as deserializer parallel output and `hblank`).
- `reset_n` in 1: asynchronous, active-low reset.
- `align_req` in 1: one-cycle pulse that starts or restarts training.
- `rx_valid` in 1: `rx_data` word valid this cycle.
- `rx_data` in 32: deserialized word, {chA, chB}.
- `hblank` in 1: high during horizontal blanking.
- `bitslip` out 1: one-cycle slip pulse to the deserializer.
- `locked` out 1: alignment achieved.
- `align_fail` out 1: training exhausted `MAX_SLIPS`.
- `pix_valid` out 1, `pix_ready` in 1: output handshake.
- `pix_data` out 32: {chA, chB} pixel pair.
- `pix_sol` out 1: pair is the first of a line.
- `pix_eol` out 1: pair is the last of a line.
- `overflow` out 1: sticky, set when a pair was dropped because the FIFO was full.
- `short_line` out 1: sticky, set when `hblank` rose before `LINE_PAIRS` pairs were captured.

## Operation

- Reset values: all outputs 0; FSM in IDLE; FIFO empty; all counters 0.
- FSM states: IDLE, CHECK, SLIP, WAIT, LOCKED, FAIL.
- `align_req` in any state has the following effects:
  - next state is CHECK;
  - slip count and match count cleared;
  - FIFO flushed;
  - `locked`, `align_fail`, `overflow` and `short_line` cleared.
- CHECK, evaluated on each `rx_valid` cycle:
  - If both channels equal `TRAIN_PATTERN`, match count increments. When it reaches `LOCK_COUNT`, go to LOCKED.
  - On any mismatch, match count is cleared. If slip count < `MAX_SLIPS`, go to SLIP; otherwise go to FAIL.
- SLIP lasts one cycle: `bitslip` = 1, slip count increments, then go to WAIT.
- WAIT lasts `SLIP_WAIT` cycles, ignoring `rx_data`, then returns to CHECK.
- FAIL holds `align_fail` = 1 until the next `align_req`.
- LOCKED:
  - Holds `locked` = 1.
  - A capture occurs when `rx_valid` = 1, `hblank` = 0 and pair count < `LINE_PAIRS`. The pair is written with:
    - `pix_sol` = (pair count == 0);
    - `pix_eol` = (pair count == `LINE_PAIRS`-1).
  - Pair count increments on each capture. Pairs received after `LINE_PAIRS` within the same line are discarded silently.
  - On the rising edge of `hblank`: if pair count is neither 0 nor `LINE_PAIRS`, set `short_line`. Pair count is cleared in either case.
  - A capture attempted while the FIFO is full is dropped, sets `overflow`, and still increments pair count.
  - Alignment is not re-checked while LOCKED; only `align_req` re-trains.
- FIFO:
  - Show-ahead; entry is {sol, eol, data} (34 bits).
  - A pop occurs on `pix_valid` & `pix_ready`.
  - A simultaneous push and pop when full succeeds (no drop).
  - Outputs `pix_data`/`pix_sol`/`pix_eol` are stable while `pix_valid` is high and `pix_ready` is low.

## Timing

- Capture latency: a qualifying `rx_valid` in cycle N is registered at the end of N and written to the FIFO at the end of N+1. If the FIFO was empty, `pix_valid` rises in cycle N+2.
- Throughput: one pair per clock sustained while `pix_ready` = 1.
- `bitslip` is high for exactly one cycle per SLIP visit. Consecutive pulses are separated by at least `SLIP_WAIT`+1 cycles.
- `locked` rises in the cycle after the `LOCK_COUNT`th matching `rx_valid`.
- `hblank` edge detection uses a one-cycle delayed copy.
- `reset_n` assertion mid-line or mid-training returns the block to reset values asynchronously. Release is synchronous to `clk`, via a two-flop release synchronizer.

## Structure

- Package `adc_rx_pkg` holds:
  - the FSM state enum;
  - the pair entry struct {sol, eol, data[31:0]};
  - the default `TRAIN_PATTERN` constant.
- Sub-module `sync_fifo` (parameterized width and depth, show-ahead, count-based full/empty) implements the pair buffer.
- The FSM, line framing and sticky flags live in the top module.

## Test plan

1. Aligned from start: `align_req`, then 16 words of F00F/F00F → no `bitslip`; `locked` = 1 in the cycle after the 16th word.
2. Misaligned by 3: the deserializer model rotates the data until it has seen 3 slips. Expect exactly 3 `bitslip` pulses, each ≥5 cycles apart, then `locked` = 1.
3. Never matches: constant 0x1234 input → 7 `bitslip` pulses, then `align_fail` = 1 and `locked` = 0.
4. Locked, `LINE_PAIRS` = 800, `hblank` low for 810 valid cycles with `pix_ready` = 1:
   - 800 pairs out in order;
   - `pix_sol` on pair 0, `pix_eol` on pair 799;
   - no flags set;
   - first `pix_valid` 2 cycles after the first capture.
5. `pix_ready` = 0 for a 20-pair line with `FIFO_DEPTH` = 16 → 16 pairs retained and `overflow` = 1. When released, 16 pairs drain with stable data during the stall.
6. `hblank` rises after 500 pairs → `short_line` = 1. The next line starts with `pix_sol` at pair count 0. `reset_n` pulsed low mid-line clears all outputs within the same cycle.

Source files
------------

// File: rtl/adc_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_rx_pkg
// Description : Shared types and constants for the AFE LVDS pixel framer.
//               - state_t : word-alignment / capture FSM states
//               - pair_t  : FIFO entry {sol, eol, data[31:0]}
//               - TRAIN_PATTERN_DEFAULT : AFE test word used for training
// Revision    : 1.0 - initial release
// ============================================================================
package adc_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_SLIP   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAIL   = 3'd5
  } state_t;

  typedef struct packed {
    logic        sol;
    logic        eol;
    logic [31:0] data;
  } pair_t;

  localparam int          PAIR_W                = $bits(pair_t);
  localparam logic [15:0] TRAIN_PATTERN_DEFAULT = 16'hF00F;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock show-ahead FIFO with count-based full/empty.
//               The head entry is visible on dout whenever empty is low.
//               A push while full is accepted only if a pop happens in the
//               same cycle. flush empties the FIFO synchronously.
// Ports       : clk, rst_n (async active-low), flush,
//               push/din, pop/dout, full, empty
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  // A pop frees the slot this cycle, so a push into a full FIFO still lands.
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc_pixel_framer.sv
`default_nettype none
// ============================================================================
// Module      : adc_pixel_framer
// Description : Trains word alignment of a 4-lane 8:1 LVDS deserializer
//               against the AFE test pattern (bitslip search), then frames
//               active-line pixel pairs using hblank and streams them out
//               through a pair FIFO on a valid/ready interface.
// Ports       : clk, reset_n        - sensor clock, async active-low reset
//               align_req           - start/restart training
//               rx_valid, rx_data   - deserialized word {chA, chB}
//               hblank              - horizontal blanking
//               bitslip             - slip pulse to the deserializer
//               locked, align_fail  - training status
//               pix_valid/ready, pix_data, pix_sol, pix_eol - pair stream
//               overflow, short_line- sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
module adc_pixel_framer
  import adc_rx_pkg::*;
#(
  parameter logic [15:0] TRAIN_PATTERN = TRAIN_PATTERN_DEFAULT,
  parameter int          LOCK_COUNT    = 16,
  parameter int          SLIP_WAIT     = 4,
  parameter int          MAX_SLIPS     = 7,
  parameter int          LINE_PAIRS    = 800,
  parameter int          FIFO_DEPTH    = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        align_req,
  input  logic        rx_valid,
  input  logic [31:0] rx_data,
  input  logic        hblank,
  output logic        bitslip,
  output logic        locked,
  output logic        align_fail,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [31:0] pix_data,
  output logic        pix_sol,
  output logic        pix_eol,
  output logic        overflow,
  output logic        short_line
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int SW = $clog2(MAX_SLIPS + 1);
  localparam int WW = $clog2(SLIP_WAIT + 1);
  localparam int PW = $clog2(LINE_PAIRS + 1);

  // Reset asserts asynchronously; release is retimed through two flops.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // ---------------------------------------------------------------- FSM
  state_t        state, state_nxt;
  logic [MW-1:0] match_cnt, match_nxt;
  logic [SW-1:0] slip_cnt, slip_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic          pattern_ok;

  assign pattern_ok = (rx_data[31:16] == TRAIN_PATTERN) && (rx_data[15:0] == TRAIN_PATTERN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      match_cnt <= '0;
      slip_cnt  <= '0;
      wait_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      match_cnt <= match_nxt;
      slip_cnt  <= slip_nxt;
      wait_cnt  <= wait_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    match_nxt = match_cnt;
    slip_nxt  = slip_cnt;
    wait_nxt  = wait_cnt;
    if (align_req) begin
      state_nxt = ST_CHECK;
      match_nxt = '0;
      slip_nxt  = '0;
      wait_nxt  = '0;
    end else begin
      case (state)
        ST_CHECK: begin
          if (rx_valid) begin
            if (pattern_ok) begin
              match_nxt = match_cnt + 1'b1;
              if (match_cnt == MW'(LOCK_COUNT - 1)) state_nxt = ST_LOCKED;
            end else begin
              match_nxt = '0;
              state_nxt = (slip_cnt < SW'(MAX_SLIPS)) ? ST_SLIP : ST_FAIL;
            end
          end
        end
        ST_SLIP: begin
          slip_nxt  = slip_cnt + 1'b1;
          wait_nxt  = '0;
          state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt == WW'(SLIP_WAIT - 1)) begin
            wait_nxt  = '0;
            state_nxt = ST_CHECK;
          end else begin
            wait_nxt = wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
    bitslip    = (state == ST_SLIP);
    locked     = (state == ST_LOCKED);
    align_fail = (state == ST_FAIL);
  end

  // ------------------------------------------------------- line framing
  logic          hblank_d;
  logic          hblank_rise;
  logic [PW-1:0] pair_cnt;
  logic          capture;
  logic          cap_valid;
  pair_t         cap_entry;
  pair_t         head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          drop;

  assign hblank_rise = locked & hblank & ~hblank_d;
  assign capture     = locked & ~align_req & rx_valid & ~hblank & (pair_cnt < PW'(LINE_PAIRS));
  assign pop         = pix_valid & pix_ready;
  // Full FIFO without a same-cycle pop cannot take the registered pair.
  assign drop        = cap_valid & fifo_full & ~pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hblank_d   <= 1'b0;
      pair_cnt   <= '0;
      cap_valid  <= 1'b0;
      cap_entry  <= '0;
      overflow   <= 1'b0;
      short_line <= 1'b0;
    end else begin
      hblank_d  <= hblank;
      cap_valid <= capture;
      if (capture) begin
        cap_entry <= '{sol: (pair_cnt == '0), eol: (pair_cnt == PW'(LINE_PAIRS - 1)), data: rx_data};
      end
      if (align_req) begin
        pair_cnt   <= '0;
        overflow   <= 1'b0;
        short_line <= 1'b0;
      end else begin
        if (hblank_rise) begin
          pair_cnt <= '0;
          if ((pair_cnt != '0) && (pair_cnt != PW'(LINE_PAIRS))) short_line <= 1'b1;
        end else if (capture) begin
          pair_cnt <= pair_cnt + 1'b1;
        end
        if (drop) overflow <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (PAIR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_pair_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (align_req),
    .push  (cap_valid & ~align_req),
    .din   (cap_entry),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign pix_valid = ~fifo_empty;
  assign pix_data  = pix_valid ? head.data : 32'd0;
  assign pix_sol   = pix_valid & head.sol;
  assign pix_eol   = pix_valid & head.eol;

endmodule
`default_nettype wire

// File: tb/tb_adc_pixel_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_pixel_framer
// Description : Directed self-checking bench for adc_pixel_framer with
//               default parameters (LOCK_COUNT 16, SLIP_WAIT 4, MAX_SLIPS 7,
//               LINE_PAIRS 800, FIFO_DEPTH 16). A small deserializer model
//               rotates each byte lane until it has seen a number of slips.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_pixel_framer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        align_req = 1'b0;
  logic        rx_valid = 1'b0;
  logic [31:0] rx_data = 32'd0;
  logic        hblank = 1'b1;
  logic        pix_ready = 1'b0;
  logic        bitslip, locked, align_fail, pix_valid, pix_sol, pix_eol;
  logic        overflow, short_line;
  logic [31:0] pix_data;

  adc_pixel_framer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .align_req  (align_req),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .hblank     (hblank),
    .bitslip    (bitslip),
    .locked     (locked),
    .align_fail (align_fail),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .pix_sol    (pix_sol),
    .pix_eol    (pix_eol),
    .overflow   (overflow),
    .short_line (short_line)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else             passed++;
  endtask

  // ----------------------------------------------------------- monitors
  int          cyc = 0;
  int          slip_pulses = 0;
  int          last_slip = -100;
  int          gap_viol = 0;
  int          stall_viol = 0;
  logic        prev_stall = 1'b0;
  logic [33:0] prev_head = '0;
  logic [33:0] out_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bitslip) begin
      if (cyc - last_slip < 5) gap_viol++;
      last_slip = cyc;
      slip_pulses++;
    end
    if (pix_valid && pix_ready) out_q.push_back({pix_sol, pix_eol, pix_data});
    if (pix_valid && !pix_ready && prev_stall && ({pix_sol, pix_eol, pix_data} !== prev_head))
      stall_viol++;
    prev_stall = pix_valid && !pix_ready;
    prev_head  = {pix_sol, pix_eol, pix_data};
  end

  // ------------------------------------------------------------ helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Each byte lane rotated left by k bits relative to the aligned pattern.
  function automatic logic [31:0] deser(input int k);
    logic [31:0] w;
    logic [31:0] r;
    logic [7:0]  x;
    w = 32'hF00FF00F;
    r = '0;
    for (int b = 0; b < 4; b++) begin
      x = w[b*8 +: 8];
      r[b*8 +: 8] = (x << k) | (x >> (8 - k));
    end
    return r;
  endfunction

  function automatic logic [39:0] all_outs();
    return {bitslip, locked, align_fail, pix_valid, pix_sol, pix_eol, overflow, short_line, pix_data};
  endfunction

  task automatic do_lock();
    align_req = 1'b1;
    tick();
    align_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rx_valid = 1'b1;
      rx_data  = 32'hF00FF00F;
      tick();
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_pairs(input int n, input logic [15:0] tag_a);
    for (int i = 0; i < n; i++) begin
      rx_valid = 1'b1;
      rx_data  = {tag_a, 16'(i)};
      tick();
    end
    rx_valid = 1'b0;
  endtask

  // --------------------------------------------------------------- main
  initial begin
    int base, gbase, sbase, n, k, errs;
    logic [31:0] d;

    repeat (3) tick();
    check_eq("reset_outputs", 64'(all_outs()), 64'd0);
    reset_n = 1'b1;
    repeat (4) tick();
    check_eq("idle_outputs", 64'(all_outs()), 64'd0);

    // 1: aligned from the start
    base = slip_pulses;
    align_req = 1'b1;
    tick();
    align_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rx_valid = 1'b1;
      rx_data  = 32'hF00FF00F;
      if (i == 15) check_eq("t1_locked_on_16th", 64'(locked), 64'd0);
      tick();
    end
    rx_valid = 1'b0;
    check_eq("t1_locked_after_16th", 64'(locked), 64'd1);
    check_eq("t1_no_bitslip", 64'(slip_pulses - base), 64'd0);

    // 2: misaligned by three slips
    base  = slip_pulses;
    gbase = gap_viol;
    align_req = 1'b1;
    tick();
    align_req = 1'b0;
    n = 0;
    while (!locked && n < 300) begin
      k = 3 - (slip_pulses - base);
      if (k < 0) k = 1;
      rx_valid = 1'b1;
      rx_data  = deser(k);
      tick();
      n++;
    end
    rx_valid = 1'b0;
    check_eq("t2_locked", 64'(locked), 64'd1);
    check_eq("t2_slip_count", 64'(slip_pulses - base), 64'd3);
    check_eq("t2_slip_spacing_viol", 64'(gap_viol - gbase), 64'd0);

    // 3: never matches
    base = slip_pulses;
    align_req = 1'b1;
    tick();
    align_req = 1'b0;
    n = 0;
    while (!align_fail && n < 300) begin
      rx_valid = 1'b1;
      rx_data  = 32'h12341234;
      tick();
      n++;
    end
    rx_valid = 1'b0;
    repeat (10) tick();
    check_eq("t3_align_fail", 64'(align_fail), 64'd1);
    check_eq("t3_locked", 64'(locked), 64'd0);
    check_eq("t3_slip_count", 64'(slip_pulses - base), 64'd7);

    // 4: full 800-pair line, 810 valid cycles, ready held high
    do_lock();
    pix_ready = 1'b1;
    hblank    = 1'b0;
    out_q.delete();
    for (int i = 0; i < 810; i++) begin
      rx_valid = 1'b1;
      rx_data  = {16'(i), 16'(i) ^ 16'hA5A5};
      if (i == 1) check_eq("t4_valid_at_n+1", 64'(pix_valid), 64'd0);
      if (i == 2) check_eq("t4_valid_at_n+2", 64'(pix_valid), 64'd1);
      tick();
    end
    rx_valid = 1'b0;
    repeat (5) tick();
    hblank = 1'b1;
    repeat (3) tick();
    check_eq("t4_pair_count", 64'(out_q.size()), 64'd800);
    errs = 0;
    for (int i = 0; i < out_q.size(); i++) begin
      d = {16'(i), 16'(i) ^ 16'hA5A5};
      if (out_q[i] !== {(i == 0), (i == 799), d}) errs++;
    end
    check_eq("t4_order_errors", 64'(errs), 64'd0);
    if (out_q.size() == 800) begin
      check_eq("t4_first_pair", 64'(out_q[0]), 64'({1'b1, 1'b0, 32'h0000A5A5}));
      check_eq("t4_last_pair", 64'(out_q[799]), 64'({1'b0, 1'b1, 16'd799, 16'd799 ^ 16'hA5A5}));
    end
    check_eq("t4_flags", 64'({overflow, short_line}), 64'd0);

    // 5: stalled 20-pair line into a 16-deep FIFO
    pix_ready = 1'b0;
    hblank    = 1'b0;
    out_q.delete();
    sbase = stall_viol;
    send_pairs(20, 16'h0100);
    repeat (6) tick();
    check_eq("t5_overflow", 64'(overflow), 64'd1);
    check_eq("t5_head_while_stalled", 64'({pix_valid, pix_sol, pix_eol, pix_data}),
             64'({1'b1, 1'b1, 1'b0, 16'h0100, 16'd0}));
    pix_ready = 1'b1;
    repeat (25) tick();
    check_eq("t5_drained_count", 64'(out_q.size()), 64'd16);
    errs = 0;
    for (int i = 0; i < out_q.size(); i++)
      if (out_q[i] !== {(i == 0), 1'b0, 16'h0100, 16'(i)}) errs++;
    check_eq("t5_drain_errors", 64'(errs), 64'd0);
    check_eq("t5_stall_stability_viol", 64'(stall_viol - sbase), 64'd0);
    hblank = 1'b1;
    repeat (2) tick();
    check_eq("t5_short_line_20", 64'(short_line), 64'd1);

    // 6: short line of 500 pairs, then a fresh line
    do_lock();
    check_eq("t6_flags_cleared", 64'({overflow, short_line}), 64'd0);
    hblank = 1'b0;
    out_q.delete();
    send_pairs(500, 16'h0200);
    repeat (4) tick();
    check_eq("t6_no_short_before_hblank", 64'(short_line), 64'd0);
    hblank = 1'b1;
    repeat (2) tick();
    check_eq("t6_short_line", 64'(short_line), 64'd1);
    check_eq("t6_pairs_out", 64'(out_q.size()), 64'd500);
    out_q.delete();
    hblank = 1'b0;
    send_pairs(3, 16'hBEEF);
    repeat (5) tick();
    check_eq("t6_next_line_count", 64'(out_q.size()), 64'd3);
    if (out_q.size() == 3)
      check_eq("t6_next_line_sol", 64'(out_q[0]), 64'({1'b1, 1'b0, 16'hBEEF, 16'd0}));

    // Reset mid-line with data pending
    pix_ready = 1'b0;
    send_pairs(5, 16'h0300);
    repeat (3) tick();
    check_eq("rst_pre_state", 64'({locked, pix_valid, short_line}), 64'b111);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rst_async_clear", 64'(all_outs()), 64'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (4) tick();
    check_eq("rst_after_release", 64'(all_outs()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
